// File: rtl/mcs_io_pkg.sv
// rtl/mcs_io_pkg.sv - shared types and defaults for the MCS IO bus master
package mcs_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [31:0] IO_BASE_DEF = 32'hc000_0000;
  localparam logic [31:0] IO_MASK_DEF = 32'hc000_0000;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  // An address belongs to the IO window when its masked bits equal the base
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/io_wdog_timer.sv
// rtl/io_wdog_timer.sv - counts WAIT cycles and flags the last allowed one
module io_wdog_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] count;

  // Count enabled cycles; clear has priority so every transaction starts from zero
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // count holds the number of earlier enabled cycles, so this fires on the
  // TIMEOUT_CYC-th enabled cycle itself
  assign expired = enable && (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mcs_io_master.sv
// rtl/mcs_io_master.sv - single-outstanding initiator for the MCS IO bus
module mcs_io_master
  import mcs_io_pkg::*;
#(
  parameter logic [31:0] IO_BASE     = IO_BASE_DEF,
  parameter logic [31:0] IO_MASK     = IO_MASK_DEF,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        io_addr_strobe,
  output logic        io_read_strobe,
  output logic        io_write_strobe,
  output logic [3:0]  io_byte_enable,
  output logic [31:0] io_address,
  output logic [31:0] io_write_data,
  input  logic [31:0] io_read_data,
  input  logic        io_ready
);

  state_t state;
  state_t next_state;

  logic  wr_q;
  resp_t rsp_q;
  resp_t rsp_d;
  logic  addr_strobe_d;
  logic  read_strobe_d;
  logic  write_strobe_d;
  logic  rsp_valid_d;
  logic  accept;
  logic  hit;
  logic  timer_expired;

  assign accept    = (state == ST_IDLE) && cmd_valid;
  assign hit       = in_window(cmd_addr, IO_BASE, IO_MASK);
  assign cmd_ready = (state == ST_IDLE);

  io_wdog_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state != ST_WAIT),
    .enable  (state == ST_WAIT),
    .expired (timer_expired)
  );

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; a ready that coincides with expiry still completes normally
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (cmd_valid) next_state = hit ? ST_STROBE : ST_RESP;
      ST_STROBE: next_state = ST_WAIT;
      ST_WAIT:   if (io_ready || timer_expired) next_state = ST_RESP;
      ST_RESP:   if (rsp_ready) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs, derived from the upcoming state
  always_comb begin
    addr_strobe_d  = accept && hit;
    read_strobe_d  = accept && hit && !cmd_wr;
    write_strobe_d = accept && hit && cmd_wr;
    rsp_valid_d    = (next_state == ST_RESP);
    rsp_d          = rsp_q;
    if (accept && !hit) begin
      rsp_d.rdata = 32'h0;
      rsp_d.err   = 1'b1;
    end else if (state == ST_WAIT) begin
      if (io_ready) begin
        rsp_d.rdata = wr_q ? 32'h0 : io_read_data;
        rsp_d.err   = 1'b0;
      end else if (timer_expired) begin
        rsp_d.rdata = 32'h0;
        rsp_d.err   = 1'b1;
      end
    end
  end

  // Output and command registers; bus fields only change on an in-window accept
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q            <= 1'b0;
      rsp_q           <= '0;
      rsp_valid       <= 1'b0;
      io_addr_strobe  <= 1'b0;
      io_read_strobe  <= 1'b0;
      io_write_strobe <= 1'b0;
      io_byte_enable  <= 4'h0;
      io_address      <= 32'h0;
      io_write_data   <= 32'h0;
    end else begin
      rsp_q           <= rsp_d;
      rsp_valid       <= rsp_valid_d;
      io_addr_strobe  <= addr_strobe_d;
      io_read_strobe  <= read_strobe_d;
      io_write_strobe <= write_strobe_d;
      if (accept) begin
        wr_q <= cmd_wr;
      end
      if (accept && hit) begin
        io_byte_enable <= cmd_be;
        io_address     <= cmd_addr;
        io_write_data  <= cmd_wdata;
      end
    end
  end

  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_mcs_io_master.sv
// tb/tb_mcs_io_master.sv - directed self-checking bench for mcs_io_master
module tb_mcs_io_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        io_addr_strobe;
  logic        io_read_strobe;
  logic        io_write_strobe;
  logic [3:0]  io_byte_enable;
  logic [31:0] io_address;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        io_ready;

  int n_cmp = 0;
  int n_err = 0;

  mcs_io_master #(
    .TIMEOUT_CYC(4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_wr          (cmd_wr),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .cmd_be          (cmd_be),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .io_addr_strobe  (io_addr_strobe),
    .io_read_strobe  (io_read_strobe),
    .io_write_strobe (io_write_strobe),
    .io_byte_enable  (io_byte_enable),
    .io_address      (io_address),
    .io_write_data   (io_write_data),
    .io_read_data    (io_read_data),
    .io_ready        (io_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_be    = be;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_idle_cmd_ready"}, 128'(cmd_ready), 128'(1));
    chk({tag, "_idle_rsp_valid"}, 128'(rsp_valid), 128'(0));
  endtask

  initial begin
    reset_n      = 1'b0;
    cmd_valid    = 1'b0;
    cmd_wr       = 1'b0;
    cmd_addr     = 32'h0;
    cmd_wdata    = 32'h0;
    cmd_be       = 4'h0;
    rsp_ready    = 1'b0;
    io_read_data = 32'h0;
    io_ready     = 1'b0;
    tick();
    tick();

    chk("reset_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("reset_outputs",
        128'({rsp_valid, rsp_rdata, rsp_err, io_addr_strobe, io_read_strobe, io_write_strobe,
              io_byte_enable, io_address, io_write_data}), 128'(0));
    reset_n = 1'b1;
    tick();

    // 1: write, slave ready one cycle after strobe
    issue(1'b1, 32'hc000_0010, 32'h0000_00aa, 4'hf);
    chk("t1_strobes", 128'({io_addr_strobe, io_write_strobe, io_read_strobe}), 128'(3'b110));
    chk("t1_bus", 128'({io_byte_enable, io_address, io_write_data}),
        128'({4'hf, 32'hc000_0010, 32'h0000_00aa}));
    chk("t1_cmd_ready_busy", 128'(cmd_ready), 128'(0));
    tick();
    chk("t1_wait_strobes", 128'({io_addr_strobe, io_write_strobe, io_read_strobe}), 128'(0));
    chk("t1_wait_no_rsp", 128'(rsp_valid), 128'(0));
    io_ready     = 1'b1;
    io_read_data = 32'hffff_ffff;
    tick();
    io_ready = 1'b0;
    chk("t1_rsp", 128'({rsp_valid, rsp_err, rsp_rdata}), 128'({1'b1, 1'b0, 32'h0}));
    finish_rsp("t1");

    // 2: read, ready on 4th WAIT cycle (same cycle as timeout: ready wins)
    issue(1'b0, 32'hc000_0004, 32'h0, 4'hf);
    chk("t2_strobes", 128'({io_addr_strobe, io_write_strobe, io_read_strobe}), 128'(3'b101));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_wait_addr", 128'(io_address), 128'(32'hc000_0004));
      chk("t2_wait_no_rsp", 128'(rsp_valid), 128'(0));
    end
    tick();
    chk("t2_wait4_addr", 128'(io_address), 128'(32'hc000_0004));
    io_ready     = 1'b1;
    io_read_data = 32'h1234_5678;
    tick();
    io_ready     = 1'b0;
    io_read_data = 32'h0;
    chk("t2_rsp", 128'({rsp_valid, rsp_err, rsp_rdata}), 128'({1'b1, 1'b0, 32'h1234_5678}));

    // 5: consumer stalls for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_stall_rsp", 128'({rsp_valid, rsp_err, rsp_rdata}), 128'({1'b1, 1'b0, 32'h1234_5678}));
      chk("t5_stall_cmd_ready", 128'(cmd_ready), 128'(0));
    end
    finish_rsp("t5");

    // 3: out-of-window read
    issue(1'b0, 32'h0000_1000, 32'h0, 4'hf);
    chk("t3_no_strobes", 128'({io_addr_strobe, io_write_strobe, io_read_strobe}), 128'(0));
    chk("t3_rsp", 128'({rsp_valid, rsp_err, rsp_rdata}), 128'({1'b1, 1'b1, 32'h0}));
    finish_rsp("t3");

    // 4: slave never ready, TIMEOUT_CYC = 4
    issue(1'b0, 32'hc000_0020, 32'h0, 4'h3);
    chk("t4_strobe", 128'(io_read_strobe), 128'(1));
    tick();
    chk("t4_wait1_no_rsp", 128'(rsp_valid), 128'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_wait_no_rsp", 128'(rsp_valid), 128'(0));
    end
    tick();
    chk("t4_timeout_rsp", 128'({rsp_valid, rsp_err, rsp_rdata}), 128'({1'b1, 1'b1, 32'h0}));
    io_ready     = 1'b1;
    io_read_data = 32'hdead_beef;
    tick();
    io_ready = 1'b0;
    chk("t4_late_ready_in_resp", 128'({rsp_valid, rsp_err, rsp_rdata}), 128'({1'b1, 1'b1, 32'h0}));
    finish_rsp("t4");
    io_ready = 1'b1;
    tick();
    io_ready = 1'b0;
    chk("t4_late_ready_in_idle", 128'({cmd_ready, rsp_valid}), 128'(2'b10));

    // 4b: next command runs normally; ready during STROBE is ignored
    issue(1'b0, 32'hc000_0024, 32'h0, 4'hf);
    io_ready     = 1'b1;
    io_read_data = 32'hdead_beef;
    tick();
    io_ready = 1'b0;
    chk("t4b_strobe_ready_ignored", 128'(rsp_valid), 128'(0));
    io_ready     = 1'b1;
    io_read_data = 32'h0000_55aa;
    tick();
    io_ready = 1'b0;
    chk("t4b_rsp", 128'({rsp_valid, rsp_err, rsp_rdata}), 128'({1'b1, 1'b0, 32'h0000_55aa}));
    finish_rsp("t4b");

    // 6: reset during WAIT abandons the transaction
    issue(1'b1, 32'hc000_0030, 32'h1111_2222, 4'h5);
    tick();
    reset_n = 1'b0;
    tick();
    chk("t6_reset_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("t6_reset_outputs",
        128'({rsp_valid, rsp_rdata, rsp_err, io_addr_strobe, io_read_strobe, io_write_strobe,
              io_byte_enable, io_address, io_write_data}), 128'(0));
    reset_n  = 1'b1;
    io_ready = 1'b1;
    tick();
    io_ready = 1'b0;
    chk("t6_ready_ignored", 128'({cmd_ready, rsp_valid, io_addr_strobe}), 128'(3'b100));
    tick();
    chk("t6_no_rsp", 128'({cmd_ready, rsp_valid}), 128'(2'b10));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
